// File: rtl/pipe_stall_sequencer.sv
// pipe_stall_sequencer: stall/flush wave generator, redirect holder and fetch PC owner.
// Optional STALL_PERF_EN adds a saturating external-stall cycle counter.
`default_nettype none

module pipe_stall_sequencer #(
  parameter int              NSTAGES  = 5,
  parameter int              EX_STAGE = 2,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ext_stall_i,
  input  logic [NSTAGES-1:0] hz_stall_i,
  input  logic [NSTAGES-1:0] hz_flush_i,
  input  logic               redirect_valid_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [NSTAGES-1:0] stall_o,
  output logic [NSTAGES-1:0] flush_o,
  output logic               redirect_pending_o,
  output logic [31:0]        stall_cycles_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [NSTAGES-1:1] sw_q, sw_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    hold_pc_q, hold_pc_d;
  logic               pending_q, pending_d;
  logic               redir_cap_q, redir_cap_d;

  logic [NSTAGES-1:0] stall_src;
  logic [NSTAGES-1:0] wave_flush;
  logic [NSTAGES-1:0] redir_flush;
  logic               fetch_stall;

  always_comb begin
    sw_d         = '0;
    stall_src    = '0;
    redir_flush  = '0;
    sw_d[1]      = ext_stall_i;
    stall_src[0] = ext_stall_i;
    stall_src[1] = ext_stall_i;
    for (int k = 2; k < NSTAGES; k++) begin
      sw_d[k]      = sw_q[k-1];
      stall_src[k] = sw_q[k-1];
    end
    // Redirect flush comes only from registered state and the valid bit, never the target.
    for (int k = 1; k <= EX_STAGE; k++) begin
      redir_flush[k] = (redirect_valid_i & ~ext_stall_i) | redir_cap_q;
    end
  end

  assign wave_flush  = {stall_src[NSTAGES-1:2], 2'b00};
  assign fetch_stall = stall_src[0] | hz_stall_i[0];

  always_comb begin
    stall_o = '0;
    flush_o = '1;
    if (!reset) begin
      stall_o = stall_src | hz_stall_i;
      flush_o = hz_flush_i | wave_flush | redir_flush;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    hold_pc_d   = hold_pc_q;
    pending_d   = pending_q;
    redir_cap_d = redirect_valid_i & ext_stall_i;
    if (redirect_valid_i && ext_stall_i) begin
      hold_pc_d = redirect_pc_i;
      pending_d = 1'b1;
    end
    if (!fetch_stall) begin
      if (redirect_valid_i) begin
        pc_d      = redirect_pc_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        pc_d      = hold_pc_q;
        pending_d = 1'b0;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      sw_q        <= '0;
      hold_pc_q   <= '0;
      pending_q   <= 1'b0;
      redir_cap_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      sw_q        <= sw_d;
      hold_pc_q   <= hold_pc_d;
      pending_q   <= pending_d;
      redir_cap_q <= redir_cap_d;
    end
  end

  assign pc_o               = pc_q;
  assign redirect_pending_o = pending_q;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (ext_stall_i && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_sequencer.sv
// tb_pipe_stall_sequencer: scoreboard bench; per-cycle stimulus and expected outputs are queued together.
`default_nettype none

module tb_pipe_stall_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_stall;
  logic [4:0]  hz_stall;
  logic [4:0]  hz_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        redirect_pending;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        r;
    logic        e;
    logic        rv;
    logic [31:0] rpc;
    logic [4:0]  hs;
    logic [4:0]  hf;
  } stim_t;

  // Packed as pc | stall | flush | pending.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  st;
    logic [4:0]  fl;
    logic        pd;
  } obs_t;

  stim_t stq[$];
  obs_t  exq[$];

  pipe_stall_sequencer #(
    .NSTAGES (5),
    .EX_STAGE(2),
    .XLEN    (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ext_stall_i       (ext_stall),
    .hz_stall_i        (hz_stall),
    .hz_flush_i        (hz_flush),
    .redirect_valid_i  (redirect_valid),
    .redirect_pc_i     (redirect_pc),
    .pc_o              (pc),
    .stall_o           (stall),
    .flush_o           (flush),
    .redirect_pending_o(redirect_pending),
    .stall_cycles_o    (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic void add(logic r, logic e, logic rv, logic [31:0] rpc,
                              logic [4:0] hs, logic [4:0] hf,
                              logic [31:0] epc, logic [4:0] est, logic [4:0] efl, logic epd);
    stq.push_back('{r: r, e: e, rv: rv, rpc: rpc, hs: hs, hf: hf});
    exq.push_back('{pc: epc, st: est, fl: efl, pd: epd});
  endfunction

  // Applies the next queued stimulus just after a rising edge, samples at the falling edge.
  task automatic step(output obs_t o);
    stim_t s;
    s              = stq.pop_front();
    reset          = s.r;
    ext_stall      = s.e;
    redirect_valid = s.rv;
    redirect_pc    = s.rpc;
    hz_stall       = s.hs;
    hz_flush       = s.hf;
    @(negedge clk);
    o = '{pc: pc, st: stall, fl: flush, pd: redirect_pending};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, x;
    add(1, 0, 0, 0, 5'h00, 5'h00, 32'h0, 5'h00, 5'h1F, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h0, 5'h00, 5'h00, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h4, 5'h00, 5'h00, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h8, 5'h00, 5'h00, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'hC, 5'h00, 5'h00, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL reset_seq got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
  endtask

  task automatic test_stall_wave();
    obs_t o, x;
    add(1, 0, 0, 0, 5'h00, 5'h00, 32'h10, 5'h00, 5'h1F, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h00, 5'h00, 5'h00, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h04, 5'h00, 5'h00, 1'b0);
    add(0, 1, 0, 0, 5'h00, 5'h00, 32'h08, 5'h03, 5'h00, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h08, 5'h04, 5'h04, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h0C, 5'h08, 5'h08, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h10, 5'h10, 5'h10, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h14, 5'h00, 5'h00, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL stall_wave got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
  endtask

  task automatic test_redirect();
    obs_t o, x;
    add(0, 0, 1, 32'h40, 5'h00, 5'h00, 32'h18, 5'h00, 5'h06, 1'b0);
    add(0, 0, 0, 32'h00, 5'h00, 5'h00, 32'h40, 5'h00, 5'h00, 1'b0);
    add(0, 0, 0, 32'h00, 5'h00, 5'h00, 32'h44, 5'h00, 5'h00, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL redirect got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
  endtask

  task automatic test_redirect_held();
    obs_t o, x;
    add(0, 1, 1, 32'h80, 5'h00, 5'h00, 32'h48, 5'h03, 5'h00, 1'b0);
    add(0, 1, 0, 32'h00, 5'h00, 5'h00, 32'h48, 5'h07, 5'h06, 1'b1);
    add(0, 1, 0, 32'h00, 5'h00, 5'h00, 32'h48, 5'h0F, 5'h0C, 1'b1);
    add(0, 1, 0, 32'h00, 5'h00, 5'h00, 32'h48, 5'h1F, 5'h1C, 1'b1);
    add(0, 0, 0, 32'h00, 5'h00, 5'h00, 32'h48, 5'h1C, 5'h1C, 1'b1);
    add(0, 0, 0, 32'h00, 5'h00, 5'h00, 32'h80, 5'h18, 5'h18, 1'b0);
    add(0, 0, 0, 32'h00, 5'h00, 5'h00, 32'h84, 5'h10, 5'h10, 1'b0);
    add(0, 0, 0, 32'h00, 5'h00, 5'h00, 32'h88, 5'h00, 5'h00, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL redirect_held got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, x;
    add(0, 1, 1, 32'h100, 5'h00, 5'h00, 32'h8C, 5'h03, 5'h00, 1'b0);
    add(0, 1, 0, 32'h000, 5'h00, 5'h00, 32'h8C, 5'h07, 5'h06, 1'b1);
    add(1, 1, 0, 32'h000, 5'h00, 5'h00, 32'h8C, 5'h00, 5'h1F, 1'b1);
    add(0, 0, 0, 32'h000, 5'h00, 5'h00, 32'h00, 5'h00, 5'h00, 1'b0);
    add(0, 0, 0, 32'h000, 5'h00, 5'h00, 32'h04, 5'h00, 5'h00, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL reset_mid got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
  endtask

  task automatic test_hazard();
    obs_t o, x;
    add(0, 0, 0, 0, 5'h05, 5'h0A, 32'h08, 5'h05, 5'h0A, 1'b0);
    add(0, 1, 0, 0, 5'h00, 5'h04, 32'h08, 5'h03, 5'h04, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h04, 32'h08, 5'h04, 5'h04, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h0C, 5'h08, 5'h08, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h10, 5'h10, 5'h10, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h14, 5'h00, 5'h00, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL hazard_merge got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
  endtask

  task automatic test_perf();
    obs_t        o, x;
    logic [31:0] exp_cnt;
`ifdef STALL_PERF_EN
    exp_cnt = 32'd7;
`else
    exp_cnt = 32'd0;
`endif
    add(1, 0, 0, 0, 5'h00, 5'h00, 32'h18, 5'h00, 5'h1F, 1'b0);
    add(0, 1, 0, 0, 5'h00, 5'h00, 32'h00, 5'h03, 5'h00, 1'b0);
    add(0, 1, 0, 0, 5'h00, 5'h00, 32'h00, 5'h07, 5'h04, 1'b0);
    add(0, 1, 0, 0, 5'h00, 5'h00, 32'h00, 5'h0F, 5'h0C, 1'b0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 5'h00, 5'h00, 32'h00, 5'h1F, 5'h1C, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h00, 5'h1C, 5'h1C, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL perf_wave got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
    checks++;
    if (stall_cycles !== exp_cnt) begin
      failures++;
      $display("FAIL stall_cycles got=%0d expected=%0d", stall_cycles, exp_cnt);
    end
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h04, 5'h18, 5'h18, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h08, 5'h10, 5'h10, 1'b0);
    add(0, 0, 0, 0, 5'h00, 5'h00, 32'h0C, 5'h00, 5'h00, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL perf_drain got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
  endtask

  task automatic test_pc_wrap();
    obs_t o, x;
    add(0, 0, 1, 32'hFFFF_FFFC, 5'h00, 5'h00, 32'h0000_0010, 5'h00, 5'h06, 1'b0);
    add(0, 0, 0, 32'h0,         5'h00, 5'h00, 32'hFFFF_FFFC, 5'h00, 5'h00, 1'b0);
    add(0, 0, 0, 32'h0,         5'h00, 5'h00, 32'h0000_0000, 5'h00, 5'h00, 1'b0);
    while (stq.size() != 0) begin
      step(o);
      x = exq.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL pc_wrap got=%h expected=%h (pc|stall|flush|pend)", o, x);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    ext_stall      = 1'b0;
    hz_stall       = '0;
    hz_flush       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stall_wave();
    test_redirect();
    test_redirect_held();
    test_reset_mid();
    test_hazard();
    test_perf();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
